button_event_detector: RTL and testbench

Downstream consumer of the debouncer. Takes the debounced level and the press tick, times press and release intervals, and classifies each gesture as short press, long press or double click. Each classification produces a one-cycle pulse. The block also keeps a saturating event count for status/LED logic.

---
 rtl/button_event_detector_pkg.sv | 40 ++++
 rtl/button_event_detector_cycle_timer.sv | 35 +++
 rtl/button_event_detector.sv | 163 ++++++++++++++++
 tb/tb_button_event_detector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_detector_pkg.sv
// -----------------------------------------------------------------------------
// button_event_detector_pkg
//
// Shared configuration for the button event detector and its timer:
//   - default clock frequency and gesture timing in milliseconds
//   - the gesture FSM state type
//   - helpers that turn millisecond timings into clock-cycle counts
//
// No ports: this is a package.
// -----------------------------------------------------------------------------
package button_event_detector_pkg;

    // Clock frequency shared with the upstream debouncer.
    localparam int ClkFreqDefault       = 100_000_000;

    // A press held at least this long is a long press.
    localparam int LongPressMsDefault   = 1000;

    // Maximum gap from first release to second press for a double click.
    localparam int DoubleClickMsDefault = 300;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } btn_state_e;

    // Cycles per millisecond times milliseconds. The division comes first so
    // the intermediate product stays inside 32 bits for realistic clocks.
    function automatic int ms_to_cycles(input int freq, input int ms);
        return (freq / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : button_event_detector_pkg

// File: rtl/button_event_detector_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
//
// Free-running up counter used to time press and release intervals. The
// parent decides when to count and when to restart; limit comparison is done
// in the parent so this block stays a plain counter.
//
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous, active-high reset (count returns to 0)
//   clear_i  synchronous restart to 0; has priority over en_i
//   en_i     advance the count by one this cycle
//   count_o  current count
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= count_o + Width'(1);
        end
    end

endmodule : cycle_timer

// File: rtl/button_event_detector.sv
// -----------------------------------------------------------------------------
// button_event_detector
//
// Sits behind the switch debouncer. Times how long the button is held and how
// long it stays released, and classifies each gesture as a short press, long
// press or double click. Each classification is a one-cycle pulse; a
// saturating event counter feeds status/LED logic.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   db_level_i      debounced switch level (1 = pressed)
//   db_tick_i       one-cycle pulse on the debounced 0->1 edge
//   short_press_o   pulse: single press, released early, no second press
//   long_press_o    pulse: press held for the long-press time
//   double_click_o  pulse: second press released inside the click window
//   held_o          level: high while a long press is still held
//   event_count_o   saturating count of emitted pulses
// -----------------------------------------------------------------------------
module button_event_detector
    import button_event_detector_pkg::*;
#(
    parameter int ClkFreq       = ClkFreqDefault,
    parameter int LongPressMs   = LongPressMsDefault,
    parameter int DoubleClickMs = DoubleClickMsDefault
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       db_level_i,
    input  logic       db_tick_i,
    output logic       short_press_o,
    output logic       long_press_o,
    output logic       double_click_o,
    output logic       held_o,
    output logic [7:0] event_count_o
);

    localparam int LongCycles   = ms_to_cycles(ClkFreq, LongPressMs);
    localparam int DoubleCycles = ms_to_cycles(ClkFreq, DoubleClickMs);
    localparam int MaxCycles    = max_int(LongCycles, DoubleCycles);
    localparam int TimerW       = $clog2(MaxCycles + 1);

    // The timer reads 0 in the first cycle of a state, so reaching N-1 while
    // still in the state means N cycles have elapsed at the next edge.
    localparam logic [TimerW-1:0] LongLast   = TimerW'(LongCycles - 1);
    localparam logic [TimerW-1:0] DoubleLast = TimerW'(DoubleCycles - 1);

    // A limit below 2 would make the threshold coincide with the state's
    // entry cycle and break the one-pulse-per-gesture timing.
    generate
        if (LongCycles < 2 || DoubleCycles < 2) begin : g_bad_timing
            $error("button_event_detector: LongCycles and DoubleCycles must both be >= 2");
        end
    endgenerate

    btn_state_e        state;
    btn_state_e        state_nxt;
    logic [TimerW-1:0] timer;
    logic              timer_clear;
    logic              timer_en;
    logic              short_nxt;
    logic              long_nxt;
    logic              double_nxt;
    logic              any_event;

    cycle_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (timer_clear),
        .en_i    (timer_en),
        .count_o (timer)
    );

    // Next-state and pulse decode. Where two events collide in one cycle,
    // the button's physical activity wins: a release beats the long
    // threshold, and a new press beats the click-window timeout.
    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;

        case (state)
            IDLE: begin
                // A level that is already high without a tick is not a new
                // press; only the debouncer's edge pulse starts a gesture.
                if (db_tick_i) begin
                    state_nxt = PRESSED;
                end
            end

            PRESSED: begin
                if (!db_level_i) begin
                    state_nxt = WAIT_SECOND;
                end else if (timer == LongLast) begin
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                end
            end

            LONG_HELD: begin
                // Release after a long press is silent; the gesture was
                // already reported when the threshold was crossed.
                if (!db_level_i) begin
                    state_nxt = IDLE;
                end
            end

            WAIT_SECOND: begin
                if (db_tick_i) begin
                    state_nxt = SECOND_PRESSED;
                end else if (timer == DoubleLast) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end

            SECOND_PRESSED: begin
                // The second press is never promoted to a long press no
                // matter how long it is held.
                if (!db_level_i) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Every state change restarts the timer so each state measures its own
    // dwell time from zero.
    assign timer_clear = (state_nxt != state);
    assign timer_en    = (state == PRESSED) || (state == WAIT_SECOND);
    assign any_event   = short_nxt || long_nxt || double_nxt;

    // State plus registered outputs. Pulses are decoded one cycle ahead so
    // they appear on the same edge as the state transition that caused them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            short_press_o  <= 1'b0;
            long_press_o   <= 1'b0;
            double_click_o <= 1'b0;
            held_o         <= 1'b0;
            event_count_o  <= 8'd0;
        end else begin
            state          <= state_nxt;
            short_press_o  <= short_nxt;
            long_press_o   <= long_nxt;
            double_click_o <= double_nxt;
            held_o         <= (state_nxt == LONG_HELD);
            if (any_event && (event_count_o != 8'hFF)) begin
                event_count_o <= event_count_o + 8'd1;
            end
        end
    end

endmodule : button_event_detector

// File: tb/tb_button_event_detector.sv
// -----------------------------------------------------------------------------
// tb_button_event_detector
//
// Directed gestures plus randomized press/release sequences, each cycle
// compared against a gesture model that works from elapsed-time arithmetic
// (press time, release time) rather than from cycle timers.
// Configuration: 1 kHz clock, 20 ms long press, 8 ms click window, giving
// LongCycles = 20 and DoubleCycles = 8.
// -----------------------------------------------------------------------------
module tb_button_event_detector;

    localparam int LONG_C   = 20;
    localparam int DOUBLE_C = 8;

    logic       clk;
    logic       rst;
    logic       level;
    logic       tick;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic       held;
    logic [7:0] event_count;

    int checks   = 0;
    int failures = 0;

    // Gesture model state: times are in model cycles (edge indices).
    int n;
    int press_t;      // edge that sampled the first press tick, -1 if none
    int release_t;    // edge that sampled the first release, -1 if none
    bit second;       // second press of a double click is being held
    bit long_active;  // long press reported, button still held
    bit m_short;
    bit m_long;
    bit m_double;
    int m_count;

    button_event_detector #(
        .ClkFreq       (1000),
        .LongPressMs   (20),
        .DoubleClickMs (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .db_level_i     (level),
        .db_tick_i      (tick),
        .short_press_o  (short_press),
        .long_press_o   (long_press),
        .double_click_o (double_click),
        .held_o         (held),
        .event_count_o  (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        press_t     = -1;
        release_t   = -1;
        second      = 1'b0;
        long_active = 1'b0;
        m_short     = 1'b0;
        m_long      = 1'b0;
        m_double    = 1'b0;
        m_count     = 0;
    endtask

    // One clock edge of the gesture rules, given the inputs sampled there.
    task automatic model_step(input bit lv, input bit tk);
        m_short  = 1'b0;
        m_long   = 1'b0;
        m_double = 1'b0;
        n++;
        if (long_active) begin
            if (!lv) long_active = 1'b0;
        end else if (second) begin
            if (!lv) begin
                second   = 1'b0;
                m_double = 1'b1;
            end
        end else if (release_t >= 0) begin
            if (tk) begin
                second    = 1'b1;
                release_t = -1;
            end else if (n - release_t == DOUBLE_C) begin
                release_t = -1;
                m_short   = 1'b1;
            end
        end else if (press_t >= 0) begin
            if (!lv) begin
                release_t = n;
                press_t   = -1;
            end else if (n - press_t == LONG_C) begin
                press_t     = -1;
                long_active = 1'b1;
                m_long      = 1'b1;
            end
        end else if (tk) begin
            press_t = n;
        end
        if ((m_short || m_long || m_double) && m_count < 255) m_count++;
    endtask

    task automatic compare();
        check("short_press",  {7'd0, short_press},  {7'd0, m_short});
        check("long_press",   {7'd0, long_press},   {7'd0, m_long});
        check("double_click", {7'd0, double_click}, {7'd0, m_double});
        check("held",         {7'd0, held},         {7'd0, long_active});
        check("event_count",  event_count,          8'(m_count));
    endtask

    task automatic step(input bit lv, input bit tk);
        @(negedge clk);
        level = lv;
        tick  = tk;
        @(posedge clk);
        model_step(lv, tk);
        #1;
        compare();
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0);
    endtask

    // Tick with the rising level, then hold for a total of 'hold' cycles.
    task automatic press(input int hold);
        step(1'b1, 1'b1);
        repeat (hold - 1) step(1'b1, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        n     = 0;
        rst   = 1'b1;
        level = 1'b0;
        tick  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst = 1'b0;

        // Short press: 5 cycles held, pulse 8 cycles after release.
        press(5);
        idle(12);

        // Long press held 30 cycles: pulse at 20, silent release.
        press(30);
        idle(3);

        // Double click: second press released inside the window.
        press(3);
        idle(4);
        press(2);
        idle(3);

        // Release exactly on the long threshold, and either side of it.
        press(20);
        idle(12);
        press(19);
        idle(12);
        press(21);
        idle(3);

        // Second tick coincides with the window timeout: tick wins.
        press(2);
        idle(8);
        press(3);
        idle(3);

        // Second tick one cycle after the timeout: short, then a new press.
        press(2);
        idle(9);
        press(2);
        idle(12);

        // Level high without a tick in IDLE is not a press.
        repeat (25) step(1'b1, 1'b0);
        idle(3);

        // Extra ticks while a press is already held are ignored.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        idle(12);

        // Reset mid-PRESSED, then no pulse may follow.
        press(5);
        async_reset();
        repeat (5) step(1'b1, 1'b0);
        idle(25);

        // Reset mid-WAIT_SECOND, then no pulse may follow.
        press(3);
        idle(3);
        async_reset();
        idle(15);

        // Randomized gestures with occasional missing ticks.
        for (int g = 0; g < 200; g++) begin
            int hi;
            int lo;
            bit tk;
            hi = $urandom_range(1, 30);
            lo = $urandom_range(1, 12);
            tk = ($urandom_range(0, 9) != 0);
            step(1'b1, tk);
            repeat (hi - 1) step(1'b1, 1'b0);
            repeat (lo) step(1'b0, 1'b0);
        end
        idle(12);

        // Saturation: 300 short presses from a cleared counter.
        async_reset();
        for (int i = 0; i < 300; i++) begin
            press(2);
            idle(9);
        end
        check("count_saturated", event_count, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_button_event_detector
